// File: rtl/qvga_pkg.sv
// Shared constants, types and FSM encoding for the QVGA-to-VGA upscaling read path.
package qvga_pkg;
    localparam int SRC_W  = 320;
    localparam int SRC_H  = 240;
    localparam int DST_W  = 2 * SRC_W;
    localparam int DST_H  = 2 * SRC_H;
    localparam int PIX_W  = 12;
    localparam int ADDR_W = 17;

    typedef logic [PIX_W-1:0]  pixel_t;
    typedef logic [ADDR_W-1:0] fb_addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        EMIT = 2'd2
    } state_t;
endpackage

// File: rtl/qvga_line_buffer.sv
// One source row of pixels: synchronous write, asynchronous (LUTRAM-style) read.
module qvga_line_buffer #(
    parameter int DEPTH = 320,
    parameter int PIX_W = 12,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];
endmodule

// File: rtl/qvga_upscale_reader.sv
// Reads a SRC_W x SRC_H framebuffer row by row and replays each row twice,
// each pixel twice, producing a 2x2 replicated stream on a valid/ready port.
module qvga_upscale_reader #(
    parameter int SRC_W  = 320,
    parameter int SRC_H  = 240,
    parameter int PIX_W  = 12,
    parameter int ADDR_W = 17,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              frame_start,
    output logic              busy,
    output logic              done,
    output logic              fb_rd_en,
    output logic [ADDR_W-1:0] fb_rd_addr,
    input  logic [PIX_W-1:0]  fb_rd_data,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [PIX_W-1:0]  m_data,
    output logic              m_sof,
    output logic              m_eol,
    output logic              m_eof,
    output logic [1:0]        dbg_state
);
    import qvga_pkg::*;

    localparam int DST_W = 2 * SRC_W;
    localparam int XW    = $clog2(SRC_W);
    localparam int DXW   = $clog2(DST_W);
    localparam int YW    = $clog2(SRC_H);
    localparam int CW    = $clog2(SRC_W + RD_LAT);

    state_t            state;
    logic [CW-1:0]     fill_cnt;
    logic [ADDR_W-1:0] row_base;
    logic [YW-1:0]     sy;
    logic [DXW-1:0]    dx;
    logic              rep;
    logic              all_loaded;
    logic              issue;
    logic [XW-1:0]     sx;
    logic              load;
    logic              last_acc;
    logic [PIX_W-1:0]  buf_rdata;
    logic [RD_LAT-1:0] wr_v;
    logic [XW-1:0]     wr_x [RD_LAT];

    assign issue      = (state == FILL) && (fill_cnt < CW'(SRC_W));
    assign sx         = fill_cnt[XW-1:0];
    assign fb_rd_en   = issue;
    assign fb_rd_addr = issue ? (row_base + ADDR_W'(sx)) : '0;
    assign busy       = (state != IDLE);
    assign dbg_state  = state;

    // Stream handshake: a pixel transfers on a cycle where m_valid && m_ready;
    // once raised, m_valid and the payload/flags hold until that transfer.
    assign load     = (state == EMIT) && !all_loaded && (!m_valid || m_ready);
    assign last_acc = (state == EMIT) && all_loaded && m_valid && m_ready;

    // Read data returns RD_LAT cycles after issue; delay the column index to match.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_v <= '0;
            for (int i = 0; i < RD_LAT; i++) wr_x[i] <= '0;
        end else begin
            wr_v[0] <= issue;
            wr_x[0] <= sx;
            for (int i = 1; i < RD_LAT; i++) begin
                wr_v[i] <= wr_v[i-1];
                wr_x[i] <= wr_x[i-1];
            end
        end
    end

    qvga_line_buffer #(
        .DEPTH (SRC_W),
        .PIX_W (PIX_W),
        .AW    (XW)
    ) u_line_buf (
        .clk   (clk),
        .we    (wr_v[RD_LAT-1]),
        .waddr (wr_x[RD_LAT-1]),
        .wdata (fb_rd_data),
        .raddr (dx[DXW-1:1]),
        .rdata (buf_rdata)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            fill_cnt   <= '0;
            row_base   <= '0;
            sy         <= '0;
            dx         <= '0;
            rep        <= 1'b0;
            all_loaded <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_sof      <= 1'b0;
            m_eol      <= 1'b0;
            m_eof      <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state    <= FILL;
                        fill_cnt <= '0;
                        row_base <= '0;
                        sy       <= '0;
                    end
                end
                FILL: begin
                    if (fill_cnt == CW'(SRC_W + RD_LAT - 1)) begin
                        state      <= EMIT;
                        dx         <= '0;
                        rep        <= 1'b0;
                        all_loaded <= 1'b0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
                EMIT: begin
                    if (load) begin
                        m_valid <= 1'b1;
                        m_data  <= buf_rdata;
                        m_sof   <= (sy == '0) && !rep && (dx == '0);
                        m_eol   <= (dx == DXW'(DST_W - 1));
                        m_eof   <= (dx == DXW'(DST_W - 1)) && rep && (sy == YW'(SRC_H - 1));
                        if (dx == DXW'(DST_W - 1)) begin
                            dx <= '0;
                            if (rep) all_loaded <= 1'b1;
                            else     rep        <= 1'b1;
                        end else begin
                            dx <= dx + 1'b1;
                        end
                    end else if (last_acc) begin
                        m_valid  <= 1'b0;
                        m_sof    <= 1'b0;
                        m_eol    <= 1'b0;
                        m_eof    <= 1'b0;
                        fill_cnt <= '0;
                        if (sy == YW'(SRC_H - 1)) begin
                            state <= IDLE;
                            done  <= 1'b1;
                        end else begin
                            sy       <= sy + 1'b1;
                            row_base <= row_base + ADDR_W'(SRC_W);
                            state    <= FILL;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
